pe_vec_feeder: RTL and testbench

- Drives the 3-PE convolution row (pe_vec) from valid/ready input streams.
- Loads a 3x3 kernel, then streams ifmap columns through the row and collects one psum per completed window.
- Produces the setup-then-strobe enable pulses pe_vec expects and returns psums on a valid/ready output.
- Sits between the on-chip buffer and pe_vec in the accelerator datapath.

---
 rtl/pe_vec_feeder_pkg.sv | 29 ++
 rtl/pe_feeder_outbuf.sv | 39 +++
 rtl/pe_vec_feeder.sv | 118 +++++++++++
 tb/tb_pe_vec_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_vec_feeder_pkg.sv
// Shared widths, PE count and FSM encoding for the pe_vec feeder.
`ifndef PE_VEC_FEEDER_DEFS
`define PE_VEC_FEEDER_DEFS
`define PE_IFMAP_WID  8
`define PE_WEIGHT_WID 8
`define PE_PSUM_WID   20
`endif

package pe_vec_feeder_pkg;
    localparam int PE_NUM = 3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_W_SETUP   = 3'd1;
    localparam logic [2:0] ST_W_STROBE  = 3'd2;
    localparam logic [2:0] ST_I_SETUP   = 3'd3;
    localparam logic [2:0] ST_I_STROBE  = 3'd4;
    localparam logic [2:0] ST_WAIT_PSUM = 3'd5;
    localparam logic [2:0] ST_OUT_HOLD  = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        W_SETUP   = ST_W_SETUP,
        W_STROBE  = ST_W_STROBE,
        I_SETUP   = ST_I_SETUP,
        I_STROBE  = ST_I_STROBE,
        WAIT_PSUM = ST_WAIT_PSUM,
        OUT_HOLD  = ST_OUT_HOLD
    } state_t;
endpackage

// File: rtl/pe_feeder_outbuf.sv
// One-entry valid/ready psum holding register.
// Build option PE_FEEDER_RELU_EN clamps negative psums to zero at capture.
module pe_feeder_outbuf
    import pe_vec_feeder_pkg::*;
#(
    parameter int PSUM_WID = `PE_PSUM_WID
) (
    input  logic                gclk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [PSUM_WID-1:0] in_data,
    output logic                in_ready,
    output logic                o_valid,
    output logic [PSUM_WID-1:0] o_data,
    input  logic                o_ready
);
    logic [PSUM_WID-1:0] cap_data;

`ifdef PE_FEEDER_RELU_EN
    assign cap_data = in_data[PSUM_WID-1] ? '0 : in_data;
`else
    assign cap_data = in_data;
`endif

    // Accept a new psum when empty or when the held one drains this cycle.
    assign in_ready = !o_valid || o_ready;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (in_valid && in_ready) begin
            o_valid <= 1'b1;
            o_data  <= cap_data;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pe_vec_feeder.sv
// Feeds the 3-PE pe_vec row: kernel load, ifmap column streaming, psum return.
// Build option PE_FEEDER_RELU_EN (in pe_feeder_outbuf) enables ReLU on results.
module pe_vec_feeder
    import pe_vec_feeder_pkg::*;
#(
    parameter int IFMAP_WID   = `PE_IFMAP_WID,
    parameter int WEIGHT_WID  = `PE_WEIGHT_WID,
    parameter int PSUM_WID    = `PE_PSUM_WID,
    parameter int PSUM_LAT    = 1,
    parameter int COL_CNT_WID = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [COL_CNT_WID-1:0]       num_cols,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [PE_NUM*WEIGHT_WID-1:0] w_data,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [PE_NUM*IFMAP_WID-1:0]  i_data,
    output logic [IFMAP_WID-1:0]         pe_ifmap1,
    output logic [IFMAP_WID-1:0]         pe_ifmap2,
    output logic [IFMAP_WID-1:0]         pe_ifmap3,
    output logic [WEIGHT_WID-1:0]        pe_weight1,
    output logic [WEIGHT_WID-1:0]        pe_weight2,
    output logic [WEIGHT_WID-1:0]        pe_weight3,
    output logic                         ifmap_wen,
    output logic                         weight_wen,
    input  logic [PSUM_WID-1:0]          pe_psum,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [PSUM_WID-1:0]          o_data,
    output logic                         busy
);
    state_t                 state, state_nxt;
    logic [COL_CNT_WID-1:0] ncols, ccnt;
    logic [1:0]             kcnt, lat_cnt;
    logic                   w_hs, i_hs, lat_done, cap, ob_in_ready, last_col;

    // Kernel columns travel with their paired ifmap column, so both valids gate the transfer.
    assign w_hs     = (state == W_SETUP) && w_valid && i_valid;
    assign i_hs     = (state == I_SETUP) && i_valid;
    assign w_ready  = (state == W_SETUP) && i_valid;
    assign i_ready  = ((state == W_SETUP) && w_valid) || (state == I_SETUP);
    assign lat_done = (lat_cnt == 2'(PSUM_LAT - 1));
    assign cap      = (state == WAIT_PSUM) && lat_done && ob_in_ready;
    assign last_col = (ccnt == ncols);

    assign weight_wen = (state == W_STROBE);
    assign ifmap_wen  = (state == W_STROBE) || (state == I_STROBE);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start && num_cols >= COL_CNT_WID'(3)) state_nxt = W_SETUP;
            W_SETUP:   if (w_hs) state_nxt = W_STROBE;
            W_STROBE:  state_nxt = (kcnt == 2'd2) ? WAIT_PSUM : W_SETUP;
            I_SETUP:   if (i_hs) state_nxt = I_STROBE;
            I_STROBE:  state_nxt = WAIT_PSUM;
            WAIT_PSUM: if (cap) state_nxt = !o_ready ? OUT_HOLD : (last_col ? IDLE : I_SETUP);
            OUT_HOLD:  if (o_valid && o_ready) state_nxt = last_col ? IDLE : I_SETUP;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ncols      <= '0;
            ccnt       <= '0;
            kcnt       <= '0;
            lat_cnt    <= '0;
            pe_ifmap1  <= '0;
            pe_ifmap2  <= '0;
            pe_ifmap3  <= '0;
            pe_weight1 <= '0;
            pe_weight2 <= '0;
            pe_weight3 <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                ncols <= num_cols;
                ccnt  <= '0;
                kcnt  <= '0;
            end
            if (w_hs) begin
                pe_weight1 <= w_data[0*WEIGHT_WID +: WEIGHT_WID];
                pe_weight2 <= w_data[1*WEIGHT_WID +: WEIGHT_WID];
                pe_weight3 <= w_data[2*WEIGHT_WID +: WEIGHT_WID];
            end
            if (w_hs || i_hs) begin
                pe_ifmap1 <= i_data[0*IFMAP_WID +: IFMAP_WID];
                pe_ifmap2 <= i_data[1*IFMAP_WID +: IFMAP_WID];
                pe_ifmap3 <= i_data[2*IFMAP_WID +: IFMAP_WID];
            end
            if (state == W_STROBE) kcnt <= kcnt + 2'd1;
            if (state == W_STROBE || state == I_STROBE) begin
                ccnt    <= ccnt + 1'b1;
                lat_cnt <= '0;
            end else if (state == WAIT_PSUM && !lat_done) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
        end
    end

    pe_feeder_outbuf #(.PSUM_WID(PSUM_WID)) u_outbuf (
        .gclk     (clk),
        .rst_n    (rst_n),
        .in_valid (cap),
        .in_data  (pe_psum),
        .in_ready (ob_in_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_ready  (o_ready)
    );
endmodule

// File: tb/tb_pe_vec_feeder.sv
// Directed bench for pe_vec_feeder with a behavioural pe_vec and a psum scoreboard.
module tb_pe_vec_feeder;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [7:0]  num_cols = 0;
    logic        w_valid = 0, i_valid = 0, o_ready = 1;
    logic        w_ready, i_ready, ifmap_wen, weight_wen, o_valid, busy;
    logic [23:0] w_data = 0, i_data = 0;
    logic [7:0]  pe_ifmap1, pe_ifmap2, pe_ifmap3, pe_weight1, pe_weight2, pe_weight3;
    logic [19:0] pe_psum, o_data;

    int total = 0, bad = 0, pops = 0, wcnt = 0;
    bit abort = 0;
    logic [19:0] sb[$];

    int wk[3][3] = '{'{-1, 9, -7}, '{0, 2, 11}, '{3, -4, 6}};
    int ic[5][3] = '{'{1, 2, 7}, '{5, 4, 8}, '{3, 6, 9}, '{2, 8, 7}, '{1, 1, 1}};

    always #5 clk = ~clk;

    pe_vec_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_cols(num_cols),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .pe_ifmap1(pe_ifmap1), .pe_ifmap2(pe_ifmap2), .pe_ifmap3(pe_ifmap3),
        .pe_weight1(pe_weight1), .pe_weight2(pe_weight2), .pe_weight3(pe_weight3),
        .ifmap_wen(ifmap_wen), .weight_wen(weight_wen), .pe_psum(pe_psum),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .busy(busy)
    );

    // Behavioural pe_vec: per-PE 3-deep weight and ifmap shift registers, psum valid one cycle after the strobe.
    logic signed [7:0] mw[3][3], mx[3][3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) for (int k = 0; k < 3; k++) begin mw[p][k] <= 0; mx[p][k] <= 0; end
        end else begin
            if (ifmap_wen) begin
                for (int p = 0; p < 3; p++) begin mx[p][2] <= mx[p][1]; mx[p][1] <= mx[p][0]; end
                mx[0][0] <= pe_ifmap1; mx[1][0] <= pe_ifmap2; mx[2][0] <= pe_ifmap3;
            end
            if (weight_wen) begin
                for (int p = 0; p < 3; p++) begin mw[p][2] <= mw[p][1]; mw[p][1] <= mw[p][0]; end
                mw[0][0] <= pe_weight1; mw[1][0] <= pe_weight2; mw[2][0] <= pe_weight3;
            end
        end
    end
    always_comb begin
        int acc;
        acc = 0;
        for (int p = 0; p < 3; p++) for (int k = 0; k < 3; k++) acc += int'(mw[p][k]) * int'(mx[p][k]);
        pe_psum = acc[19:0];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (weight_wen) wcnt++;
        if (rst_n && o_valid && o_ready) begin
            pops++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got %0d expected none", $signed(o_data));
            end else begin
                logic [19:0] e;
                e = sb.pop_front();
                if (o_data !== e) begin
                    bad++;
                    $display("FAIL result: got %0d expected %0d", $signed(o_data), $signed(e));
                end
            end
        end
    end

    function automatic logic [23:0] pk(input int a, input int b, input int c);
        logic [7:0] a8, b8, c8;
        a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0];
        return {c8, b8, a8};
    endfunction

    task automatic do_start(input int n);
        @(negedge clk); start = 1; num_cols = 8'(n);
        @(negedge clk); start = 0;
    endtask

    task automatic feed(input int n, input int sgn, input int stall_at, input int stall_len);
        logic [23:0] snap;
        bit fire;
        for (int j = 0; j < n; j++) begin
            if (j == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    if (s == 0) snap = {pe_ifmap3, pe_ifmap2, pe_ifmap1};
                    if (s >= 2) chk("stall_no_wen", int'(ifmap_wen), 0);
                    chk("stall_ifmap_hold", int'({pe_ifmap3, pe_ifmap2, pe_ifmap1} == snap), 1);
                end
            end
            w_valid = (j < 3);
            i_valid = 1;
            w_data  = (j < 3) ? pk(sgn * wk[j][0], sgn * wk[j][1], sgn * wk[j][2]) : 24'd0;
            i_data  = pk(ic[j][0], ic[j][1], ic[j][2]);
            fire = 0;
            for (int t = 0; t < 200 && !fire && !abort; t++) begin
                @(posedge clk);
                fire = (j < 3) ? (w_ready && i_ready) : i_ready;
            end
            #1; w_valid = 0; i_valid = 0;
            if (abort) return;
            if (!fire) begin
                chk("feed_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = !busy && !o_valid && sb.size() == 0;
        end
        chk("idle_reached", int'(done), 1);
    endtask

    initial begin
        #12; rst_n = 1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_readys", int'({w_ready, i_ready}), 0);
        chk("rst_wens", int'({ifmap_wen, weight_wen}), 0);
        chk("rst_o_data", int'(o_data), 0);

        // Illegal column count is ignored.
        do_start(2);
        chk("illegal_start_busy", int'(busy), 0);

        // Single window.
        sb.push_back(20'd103); wcnt = 0; pops = 0;
        do_start(3); feed(3, 1, -1, 0); wait_idle();
        chk("weight_wen_pulses", wcnt, 3);
        chk("results_n3", pops, 1);

        // Two windows.
        sb.push_back(20'd103); sb.push_back(20'd102); pops = 0;
        do_start(4); feed(4, 1, -1, 0); wait_idle();
        chk("results_n4", pops, 2);
        chk("busy_after_n4", int'(busy), 0);

        // Output back-pressure on the first result.
        sb.push_back(20'd103); sb.push_back(20'd102);
        o_ready = 0;
        do_start(4);
        fork
            feed(4, 1, -1, 0);
            begin
                bit seen;
                seen = 0;
                for (int t = 0; t < 200 && !seen; t++) begin @(negedge clk); seen = o_valid; end
                chk("stall_seen_valid", int'(seen), 1);
                for (int s = 0; s < 5; s++) begin
                    chk("hold_o_valid", int'(o_valid), 1);
                    chk("hold_o_data", int'($signed(o_data)), 103);
                    chk("hold_no_wen_rdy", int'({ifmap_wen, i_ready}), 0);
                    @(negedge clk);
                end
                o_ready = 1;
            end
        join
        wait_idle();

        // Input stall before the fourth column.
        sb.push_back(20'd103); sb.push_back(20'd102); pops = 0;
        do_start(4); feed(4, 1, 3, 6); wait_idle();
        chk("results_istall", pops, 2);

        // Reset during the second ifmap-only strobe aborts the pass.
        sb.push_back(20'd103); sb.push_back(20'd102);
        do_start(5);
        fork
            feed(5, 1, -1, 0);
            begin
                int n;
                n = 0;
                for (int t = 0; t < 300 && n < 2; t++) begin
                    @(negedge clk);
                    if (ifmap_wen && !weight_wen) n++;
                end
                chk("saw_second_istrobe", n, 2);
                #1; rst_n = 0; abort = 1;
                #1;
                chk("arst_outputs", int'({busy, ifmap_wen, weight_wen, o_valid, w_ready, i_ready}), 0);
                chk("arst_pe_data", int'({pe_ifmap1, pe_ifmap2, pe_weight1, pe_weight3}), 0);
                chk("arst_o_data", int'(o_data), 0);
                @(negedge clk); @(negedge clk); rst_n = 1;
            end
        join
        repeat (10) @(negedge clk);
        chk("no_result_after_reset", sb.size(), 0);
        abort = 0;
        sb.push_back(20'd103);
        do_start(3); feed(3, 1, -1, 0); wait_idle();

        // Negated kernel: ReLU build clamps, default build passes the negative psum.
`ifdef PE_FEEDER_RELU_EN
        sb.push_back(20'd0);
`else
        sb.push_back(20'hFFF99);
`endif
        do_start(3); feed(3, -1, -1, 0); wait_idle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
